// File: rtl/alu_pkg.sv
// Shared op-codes and FSM state encoding for the handshaked sequential ALU.
// Latency: none (declarations only); backpressure: not applicable.
package alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOR = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle logic/add/sub/slt unit; purely combinational, no backpressure.
// MUL is not handled here and yields all-zero outputs.
module alu_comb #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   output logic [WIDTH-1:0] z_o,
   output logic             cout_o,
   output logic             ovf_o
);
   import alu_pkg::*;

   logic [WIDTH:0] sum;
   logic [WIDTH:0] dif;
   logic           ovf_add;
   logic           ovf_sub;
   logic           lt;

   assign sum = {1'b0, a_i} + {1'b0, b_i};
   // Carry out of a + ~b + 1 is the "no borrow" indication.
   assign dif = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

   assign ovf_add = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
   assign ovf_sub = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (dif[WIDTH-1] != a_i[WIDTH-1]);
   assign lt      = dif[WIDTH-1] ^ ovf_sub;

   always_comb begin
      z_o    = '0;
      cout_o = 1'b0;
      ovf_o  = 1'b0;
      case (op_i)
         OP_AND: z_o = a_i & b_i;
         OP_OR:  z_o = a_i | b_i;
         OP_XOR: z_o = a_i ^ b_i;
         OP_NOR: z_o = ~(a_i | b_i);
         OP_ADD: begin
            z_o    = sum[WIDTH-1:0];
            cout_o = sum[WIDTH];
            ovf_o  = ovf_add;
         end
         OP_SUB: begin
            z_o    = dif[WIDTH-1:0];
            cout_o = dif[WIDTH];
            ovf_o  = ovf_sub;
         end
         OP_SLT: begin
            z_o    = {{(WIDTH-1){1'b0}}, lt};
            cout_o = dif[WIDTH];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: latency 1 (MUL: WIDTH+1, one shift-add step per cycle), result
// held in DONE until out_ready; in_ready only in IDLE so issue interval is >= 2.
module seq_alu #(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             zero,
   output logic             cout,
   output logic             ovf
);
   import alu_pkg::*;

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_q;
   logic [WIDTH-1:0] z_q;
   logic             zero_q;
   logic             cout_q;
   logic             ovf_q;
   logic             out_valid_q;

   logic [WIDTH-1:0] comb_z;
   logic             comb_cout;
   logic             comb_ovf;
   logic             accept;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_z;
   logic             mul_hi;
   logic [WIDTH-1:0] res_z_d;
   logic             res_cout_d;
   logic             res_ovf_d;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .a_i    (a),
      .b_i    (b),
      .op_i   (op),
      .z_o    (comb_z),
      .cout_o (comb_cout),
      .ovf_o  (comb_ovf)
   );

   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (op == OP_MUL) && MUL_EN;

   generate
      if (MUL_EN) begin : g_mul
         logic [2*WIDTH-1:0] mcand_q;
         logic [2*WIDTH-1:0] acc_q;
         logic [2*WIDTH-1:0] acc_d;
         logic [WIDTH-1:0]   mplier_q;
         logic [CW-1:0]      cnt_q;

         assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               mcand_q  <= '0;
               acc_q    <= '0;
               mplier_q <= '0;
               cnt_q    <= '0;
            end else if (mul_start) begin
               mcand_q  <= {{WIDTH{1'b0}}, a};
               mplier_q <= b;
               acc_q    <= '0;
               cnt_q    <= '0;
            end else if (state_q == ST_MUL) begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
            end
         end

         // The last step's sum is taken straight from acc_d so DONE is reached after WIDTH steps.
         assign mul_done = (cnt_q == CW'(WIDTH - 1));
         assign mul_z    = acc_d[WIDTH-1:0];
         assign mul_hi   = |acc_d[2*WIDTH-1:WIDTH];
      end else begin : g_nomul
         assign mul_done = 1'b1;
         assign mul_z    = '0;
         assign mul_hi   = 1'b0;
      end
   endgenerate

   always_comb begin
      res_z_d    = comb_z;
      res_cout_d = comb_cout;
      res_ovf_d  = comb_ovf;
      if (state_q == ST_MUL) begin
         res_z_d    = mul_z;
         res_cout_d = mul_hi;
         res_ovf_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         z_q         <= '0;
         zero_q      <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mul_start) begin
                  state_q <= ST_MUL;
               end else if (accept) begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
                  z_q         <= res_z_d;
                  zero_q      <= (res_z_d == '0);
                  cout_q      <= res_cout_d;
                  ovf_q       <= res_ovf_d;
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
                  z_q         <= res_z_d;
                  zero_q      <= (res_z_d == '0);
                  cout_q      <= res_cout_d;
                  ovf_q       <= res_ovf_d;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign z         = z_q;
   assign zero      = zero_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: 8-bit with MUL, and 16-bit with MUL disabled.
module tb_seq_alu;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       in_valid8, in_ready8, out_valid8, out_ready8, zero8, cout8, ovf8;
   logic [7:0] a8, b8, z8;
   logic [2:0] op8;

   logic        in_valid16, in_ready16, out_valid16, out_ready16, zero16, cout16, ovf16;
   logic [15:0] a16, b16, z16;
   logic [2:0]  op16;

   int checks   = 0;
   int failures = 0;

   seq_alu #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
      .z(z8), .zero(zero8), .cout(cout8), .ovf(ovf8)
   );

   seq_alu #(.WIDTH(16), .MUL_EN(1'b0)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
      .z(z16), .zero(zero16), .cout(cout16), .ovf(ovf16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge in IDLE; returns at the negedge after the accepting edge.
   task automatic send8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1;
      #1 chk("in_ready8_before_send", 32'(in_ready8), 32'd1);
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      a8 = 8'h5A; b8 = 8'hC3; op8 = OP_SUB;
      @(negedge clk);
   endtask

   task automatic send16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
      op16 = o; a16 = x; b16 = y; in_valid16 = 1'b1;
      #1 chk("in_ready16_before_send", 32'(in_ready16), 32'd1);
      @(posedge clk);
      #1 in_valid16 = 1'b0;
      a16 = 16'hA5A5; b16 = 16'h3C3C;
      @(negedge clk);
   endtask

   task automatic res8(input string tag, input logic [7:0] ez, input logic ezero,
                       input logic ecout, input logic eovf);
      chk({tag, "_valid"}, 32'(out_valid8), 32'd1);
      chk({tag, "_z"},     32'(z8),         32'(ez));
      chk({tag, "_zero"},  32'(zero8),      32'(ezero));
      chk({tag, "_cout"},  32'(cout8),      32'(ecout));
      chk({tag, "_ovf"},   32'(ovf8),       32'(eovf));
   endtask

   task automatic mul8(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] ez, input logic ecout);
      send8(OP_MUL, x, y);
      for (int n = 1; n <= 8; n++) begin
         chk({tag, "_valid_low"}, 32'(out_valid8), 32'd0);
         chk({tag, "_in_ready_low"}, 32'(in_ready8), 32'd0);
         @(negedge clk);
      end
      res8(tag, ez, 1'b0, ecout, 1'b0);
      @(negedge clk);
      chk({tag, "_drained"}, 32'(in_ready8), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; op8 = OP_AND;
      in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; op16 = OP_AND;
      repeat (2) @(posedge clk);
      in_valid8 = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid8), 32'd0);
      chk("rst_z",         32'(z8),         32'd0);
      chk("rst_zero",      32'(zero8),      32'd0);
      chk("rst_cout",      32'(cout8),      32'd0);
      chk("rst_ovf",       32'(ovf8),       32'd0);
      chk("rst_in_ready",  32'(in_ready8),  32'd0);
      in_valid8 = 1'b0;
      rst = 1'b0;

      // 1: ADD wraps to zero with carry
      send8(OP_ADD, 8'hFF, 8'h01);
      res8("add_ff_01", 8'h00, 1'b1, 1'b1, 1'b0);
      @(negedge clk);

      // 2: SUB overflow, SLT across overflow, SLT equal
      send8(OP_SUB, 8'h80, 8'h01);
      res8("sub_80_01", 8'h7F, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      send8(OP_SLT, 8'h80, 8'h7F);
      res8("slt_80_7f", 8'h01, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      send8(OP_SLT, 8'h05, 8'h05);
      res8("slt_05_05", 8'h00, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      send8(OP_NOR, 8'h0F, 8'h30);
      res8("nor_0f_30", 8'hC0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);

      // 3: multi-cycle MUL
      mul8("mul_13_11", 8'd13, 8'd11, 8'h8F, 1'b0);
      mul8("mul_ff_02", 8'hFF, 8'h02, 8'hFE, 1'b1);

      // 4: backpressure holds the XOR result; extra in_valid pulses are ignored
      out_ready8 = 1'b0;
      send8(OP_XOR, 8'hF0, 8'hFF);
      res8("xor_f0_ff", 8'h0F, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 5; n++) begin
         op8 = OP_AND; a8 = 8'h00; b8 = 8'h00; in_valid8 = 1'b1;
         @(posedge clk);
         #1 in_valid8 = 1'b0;
         @(negedge clk);
         chk("hold_valid",    32'(out_valid8), 32'd1);
         chk("hold_z",        32'(z8),         32'h0F);
         chk("hold_in_ready", 32'(in_ready8),  32'd0);
      end
      out_ready8 = 1'b1;
      @(negedge clk);
      chk("drain_valid_low", 32'(out_valid8), 32'd0);
      send8(OP_OR, 8'h11, 8'h22);
      res8("or_11_22", 8'h33, 1'b0, 1'b0, 1'b0);
      @(negedge clk);

      // 5: reset in the middle of a MUL discards it
      send8(OP_MUL, 8'd200, 8'd3);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midmul_rst_valid", 32'(out_valid8), 32'd0);
      chk("midmul_rst_z",     32'(z8),         32'd0);
      chk("midmul_rst_rdy",   32'(in_ready8),  32'd0);
      rst = 1'b0;
      send8(OP_AND, 8'hAA, 8'h0F);
      res8("and_aa_0f", 8'h0A, 1'b0, 1'b0, 1'b0);
      @(negedge clk);

      // 6: 16-bit instance without multiplier
      send16(OP_MUL, 16'h1234, 16'h5678);
      chk("w16_mul_valid", 32'(out_valid16), 32'd1);
      chk("w16_mul_z",     32'(z16),         32'd0);
      chk("w16_mul_zero",  32'(zero16),      32'd1);
      chk("w16_mul_cout",  32'(cout16),      32'd0);
      chk("w16_mul_ovf",   32'(ovf16),       32'd0);
      @(negedge clk);
      send16(OP_ADD, 16'h7FFF, 16'h0001);
      chk("w16_add_valid", 32'(out_valid16), 32'd1);
      chk("w16_add_z",     32'(z16),         32'h8000);
      chk("w16_add_zero",  32'(zero16),      32'd0);
      chk("w16_add_cout",  32'(cout16),      32'd0);
      chk("w16_add_ovf",   32'(ovf16),       32'd1);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
